fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and load-use hazard unit for the 5-stage MIPS pipeline.
- Tracks every in-flight instruction from EX through the last writeback-visible stage in an internal shadow pipeline.
- Generates per-operand forward selects for the EX-stage instruction and a load-use stall for the ID-stage instruction.
- Supersedes the purely combinational two-stage forwarding logic. Supports arbitrary source-operand count, register-address width, tracking depth and load latency.

Parameters:
- AW, 5: register address width
- NUM_SRC, 2: source operands per instruction
- DEPTH, 3: tracked stages (1=EX, 2=MEM, 3=WB); minimum 2
- LOAD_LAT, 1: a load result is not forwardable while the load sits in stages 1..LOAD_LAT
- SELW, $clog2(DEPTH): width of each forward select

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- adv  in  1  pipeline advance enable; 0 freezes all tracker state
- flush  in  1  kill the ID-stage instruction (branch/jump taken)
- id_valid  in  1  ID stage holds a real instruction
- id_rd  in  AW  ID destination register
- id_reg_write  in  1  ID instruction writes id_rd
- id_mem_read  in  1  ID instruction is a load
- id_src  in  NUM_SRC*AW  ID source registers; operand j occupies [j*AW +: AW]
- id_src_used  in  NUM_SRC  operand j actually read
- stall  out  1  hold PC and IF/ID, insert bubble into EX
- fwd_sel  out  NUM_SRC*SELW  EX operand j select: 0=register file, k=stage k+1 (1=MEM, 2=WB, ...)
- stall_cnt  out  32  stall cycles (see Optional Feature)
- fwd_cnt  out  32  forwarded operand events (see Optional Feature)

Behaviour:
- Tracker entry s[k], k=1..DEPTH: {valid, rd, wr, ld, src[NUM_SRC], used[NUM_SRC]}.
- reset: all entries invalid, all fields 0. Outputs stall=0, fwd_sel=0, counters=0, immediately and asynchronously. Reset mid-stall drops the stall the same instant.
- Entry "writes r": valid & wr & rd==r & r!=0. Register 0 never matches.
- stall (combinational): id_valid & ~flush & some j with id_src_used[j] where the youngest entry s[k] (k=1..DEPTH) writing id_src[j] has ld=1 and k<=LOAD_LAT.
- Only the youngest match is evaluated; an older load shadowed by a younger ALU write does not stall.
- fwd_sel[j] (combinational from registered state): if s[1].valid & s[1].used[j], take the youngest k in 2..DEPTH with s[k] writing s[1].src[j] and output k-1; otherwise 0. The youngest match always wins (MEM over WB).
- Clock edge, adv=1:
  - s[k] <= s[k-1] for k>=2.
  - s[1] <= ID fields if id_valid & ~flush & ~stall; otherwise a bubble (valid=0).
- Clock edge, adv=0: all entries hold; stall and fwd_sel keep re-evaluating on the held state.
- flush and stall together: flush wins. stall=0 and a bubble is inserted.
- Latency: an instruction entering EX on edge n sees its forwarding from edge n. Stall asserts in the same cycle the ID instruction is presented.
- Back-to-back loads to the same register: each is stalled independently, one cycle each for LOAD_LAT=1.

Optional Feature:
- Macro: FWD_PERF_EN.
- Defined:
  - stall_cnt increments on every adv=1 edge with stall=1.
  - fwd_cnt increments by the number of nonzero fwd_sel fields on every adv=1 edge.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package/header holds:
  - FWD_SEL_RF=0 constant
  - tracker entry field widths/offsets
  - default AW, NUM_SRC, DEPTH
  - this header is shared with the hazard/control blocks
- One sub-module: fwd_match_prio. It is a combinational youngest-match priority encoder, one instance per operand for forwarding and one per operand for the stall check.

Test Plan:
- add $3 then sub $4,$3,$5 back-to-back, adv=1 → second instruction in EX has fwd_sel[0]=1 (MEM); next instruction using $3 as operand 1 gets fwd_sel[1]=2 (WB).
- lw $2 then add $6,$2,$2 → stall=1 for exactly one cycle, bubble in s[1]; after the stall the add has fwd_sel[0]=fwd_sel[1]=2. With FWD_PERF_EN: stall_cnt=1, fwd_cnt=2.
- Writes to $0 in EX/MEM/WB, consumer reads $0 → fwd_sel=0, stall=0.
- Writes to $7 in both MEM and WB, consumer reads $7 → fwd_sel=1, youngest wins.
- Load-use hazard with flush=1 in the same cycle → stall=0 and a bubble enters EX. Separately, adv=0 for 3 cycles → tracker and fwd_sel unchanged.
- reset asserted while stall=1 → stall, fwd_sel and counters drop to 0 asynchronously; the first instruction after release sees no matches.

Source files
------------

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the forwarding/hazard unit and related control blocks.
// Tracker entry layout (LSB first): used[NUM_SRC], src[NUM_SRC*AW], ld, wr, rd[AW], valid.
package fwd_hazard_unit_pkg;

    // Forward select value meaning "take the register file".
    localparam int unsigned FWD_SEL_RF  = 0;

    localparam int unsigned DEF_AW      = 5;
    localparam int unsigned DEF_NUM_SRC = 2;
    localparam int unsigned DEF_DEPTH   = 3;

    function automatic int unsigned ent_off_used();
        return 0;
    endfunction

    function automatic int unsigned ent_off_src(int unsigned num_src);
        return num_src;
    endfunction

    function automatic int unsigned ent_off_ld(int unsigned aw, int unsigned num_src);
        return num_src + num_src * aw;
    endfunction

    function automatic int unsigned ent_off_wr(int unsigned aw, int unsigned num_src);
        return ent_off_ld(aw, num_src) + 1;
    endfunction

    function automatic int unsigned ent_off_rd(int unsigned aw, int unsigned num_src);
        return ent_off_ld(aw, num_src) + 2;
    endfunction

    function automatic int unsigned ent_off_valid(int unsigned aw, int unsigned num_src);
        return ent_off_rd(aw, num_src) + aw;
    endfunction

    function automatic int unsigned ent_width(int unsigned aw, int unsigned num_src);
        return ent_off_valid(aw, num_src) + 1;
    endfunction

endpackage

// File: rtl/fwd_match_prio.sv
// Youngest-match priority encoder: finds the lowest-index (youngest) tracker entry
// that writes addr_i. Register 0 never matches.
module fwd_match_prio #(
    parameter int unsigned AW = 5,
    parameter int unsigned N  = 3,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [AW-1:0]   addr_i,
    input  logic [N-1:0]    wr_ok_i,
    input  logic [N*AW-1:0] rd_i,
    output logic            hit_o,
    output logic [IW-1:0]   idx_o
);

    // Scan oldest to youngest so the youngest match is the last one assigned.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (wr_ok_i[i] && (rd_i[i*AW +: AW] == addr_i) && (addr_i != '0)) begin
                hit_o = 1'b1;
                idx_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit with a DEPTH-entry shadow pipeline (EX..WB).
// Optional performance counters are built when FWD_PERF_EN is defined; otherwise
// stall_cnt/fwd_cnt are tied to zero.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int unsigned AW       = DEF_AW,
    parameter int unsigned NUM_SRC  = DEF_NUM_SRC,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned SELW     = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    adv,
    input  logic                    flush,
    input  logic                    id_valid,
    input  logic [AW-1:0]           id_rd,
    input  logic                    id_reg_write,
    input  logic                    id_mem_read,
    input  logic [NUM_SRC*AW-1:0]   id_src,
    input  logic [NUM_SRC-1:0]      id_src_used,
    output logic                    stall,
    output logic [NUM_SRC*SELW-1:0] fwd_sel,
    output logic [31:0]             stall_cnt,
    output logic [31:0]             fwd_cnt
);

    localparam int unsigned EW   = ent_width(AW, NUM_SRC);
    localparam int unsigned OUSE = ent_off_used();
    localparam int unsigned OSRC = ent_off_src(NUM_SRC);
    localparam int unsigned OLD  = ent_off_ld(AW, NUM_SRC);
    localparam int unsigned OWR  = ent_off_wr(AW, NUM_SRC);
    localparam int unsigned ORD  = ent_off_rd(AW, NUM_SRC);
    localparam int unsigned OVLD = ent_off_valid(AW, NUM_SRC);
    localparam int unsigned IWS  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned IWF  = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;

    // Index 0 is stage 1 (EX).
    logic [EW-1:0]       ent_q [DEPTH];
    logic [EW-1:0]       ent_d [DEPTH];
    logic [EW-1:0]       id_ent;
    logic [DEPTH-1:0]    wr_ok;
    logic [DEPTH-1:0]    ld_v;
    logic [DEPTH*AW-1:0] rd_flat;

    logic [NUM_SRC-1:0]  st_hit;
    logic [IWS-1:0]      st_idx [NUM_SRC];
    logic [NUM_SRC-1:0]  f_hit;
    logic [IWF-1:0]      f_idx [NUM_SRC];

    assign id_ent = {id_valid, id_rd, id_reg_write, id_mem_read, id_src, id_src_used};

    // Flatten per-stage write/load info for the priority encoders.
    always_comb begin
        wr_ok   = '0;
        ld_v    = '0;
        rd_flat = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            wr_ok[k]            = ent_q[k][OVLD] & ent_q[k][OWR];
            ld_v[k]             = ent_q[k][OLD];
            rd_flat[k*AW +: AW] = ent_q[k][ORD +: AW];
        end
    end

    for (genvar j = 0; j < int'(NUM_SRC); j++) begin : g_src
        // Load-use check against all stages for the ID operand.
        fwd_match_prio #(.AW(AW), .N(DEPTH), .IW(IWS)) u_stall_prio (
            .addr_i (id_src[j*AW +: AW]),
            .wr_ok_i(wr_ok),
            .rd_i   (rd_flat),
            .hit_o  (st_hit[j]),
            .idx_o  (st_idx[j])
        );
        // Forward source search for the EX operand, stages 2..DEPTH only.
        fwd_match_prio #(.AW(AW), .N(DEPTH - 1), .IW(IWF)) u_fwd_prio (
            .addr_i (ent_q[0][OSRC + j*AW +: AW]),
            .wr_ok_i(wr_ok[DEPTH-1:1]),
            .rd_i   (rd_flat[DEPTH*AW-1:AW]),
            .hit_o  (f_hit[j]),
            .idx_o  (f_idx[j])
        );
    end

    // Stall only when the youngest writer is a load still inside the load latency.
    always_comb begin
        logic any;
        any = 1'b0;
        for (int j = 0; j < int'(NUM_SRC); j++) begin
            if (id_src_used[j] && st_hit[j] && ld_v[st_idx[j]] &&
                (32'(st_idx[j]) < LOAD_LAT)) begin
                any = 1'b1;
            end
        end
        stall = ~reset & id_valid & ~flush & any;
    end

    // Forward select: stage k maps to select value k-1.
    always_comb begin
        fwd_sel = '0;
        for (int j = 0; j < int'(NUM_SRC); j++) begin
            fwd_sel[j*SELW +: SELW] = SELW'(FWD_SEL_RF);
            if (ent_q[0][OVLD] && ent_q[0][OUSE + j] && f_hit[j]) begin
                fwd_sel[j*SELW +: SELW] = SELW'(32'(f_idx[j]) + 32'd1);
            end
        end
    end

    // Shadow pipeline shift; a stalled or flushed ID slot becomes a bubble.
    always_comb begin
        for (int k = 0; k < int'(DEPTH); k++) begin
            ent_d[k] = ent_q[k];
        end
        if (adv) begin
            for (int k = 1; k < int'(DEPTH); k++) begin
                ent_d[k] = ent_q[k-1];
            end
            ent_d[0] = (id_valid && !flush && !stall) ? id_ent : '0;
        end
    end

    // Tracker state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                ent_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                ent_q[k] <= ent_d[k];
            end
        end
    end

`ifdef FWD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fwd_cnt_q, fwd_cnt_d;
    logic [31:0] fwd_inc;

    // Saturating event counters, updated only on advancing edges.
    always_comb begin
        fwd_inc = '0;
        for (int j = 0; j < int'(NUM_SRC); j++) begin
            if (fwd_sel[j*SELW +: SELW] != '0) begin
                fwd_inc = fwd_inc + 32'd1;
            end
        end
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (adv) begin
            if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
            fwd_cnt_d = (fwd_cnt_q > (32'hFFFF_FFFF - fwd_inc)) ? 32'hFFFF_FFFF
                                                                 : fwd_cnt_q + fwd_inc;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`else
    assign stall_cnt = '0;
    assign fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit (default parameters).
module tb_fwd_hazard_unit;

    localparam int AW   = 5;
    localparam int NS   = 2;
    localparam int SELW = 2;
`ifdef FWD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             adv;
    logic             flush;
    logic             id_valid;
    logic [AW-1:0]    id_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic [NS*AW-1:0] id_src;
    logic [NS-1:0]    id_src_used;
    logic             stall;
    logic [NS*SELW-1:0] fwd_sel;
    logic [31:0]      stall_cnt;
    logic [31:0]      fwd_cnt;

    int checks = 0;
    int errors = 0;

    fwd_hazard_unit dut (
        .clk         (clk),
        .reset       (reset),
        .adv         (adv),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_rd       (id_rd),
        .id_reg_write(id_reg_write),
        .id_mem_read (id_mem_read),
        .id_src      (id_src),
        .id_src_used (id_src_used),
        .stall       (stall),
        .fwd_sel     (fwd_sel),
        .stall_cnt   (stall_cnt),
        .fwd_cnt     (fwd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sel(input int j);
        return 32'(fwd_sel[j*SELW +: SELW]);
    endfunction

    function automatic logic [31:0] pc(input int n);
        return PERF ? 32'(n) : 32'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rd, input logic wr, input logic ld,
                          input logic [4:0] s0, input logic [4:0] s1,
                          input logic u0, input logic u1);
        id_valid     = v;
        id_rd        = rd;
        id_reg_write = wr;
        id_mem_read  = ld;
        id_src       = {s1, s0};
        id_src_used  = {u1, u0};
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    // Called just after a rising edge; reset pulse stays clear of the next edge.
    task automatic pulse_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        adv   = 1'b1;
        flush = 1'b0;
        idle();
        #2;
        check("rst_stall", 32'(stall), 0);
        check("rst_sel", 32'(fwd_sel), 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_fwd_cnt", fwd_cnt, 0);
        #5;
        reset = 1'b0;

        // add $3 ; sub $4,$3,$5 ; or $8,$9,$3
        set_id(1, 3, 1, 0, 1, 2, 1, 1);
        #2;
        check("alu_nostall", 32'(stall), 0);
        step();
        set_id(1, 4, 1, 0, 3, 5, 1, 1);
        step();
        check("sub_sel0_mem", sel(0), 1);
        check("sub_sel1_rf", sel(1), 0);
        set_id(1, 8, 1, 0, 9, 3, 1, 1);
        step();
        check("or_sel1_wb", sel(1), 2);
        check("or_sel0_rf", sel(0), 0);
        idle();
        pulse_reset();

        // lw $2 ; add $6,$2,$2
        set_id(1, 2, 1, 1, 29, 0, 1, 0);
        step();
        set_id(1, 6, 1, 0, 2, 2, 1, 1);
        #2;
        check("lu_stall", 32'(stall), 1);
        step();
        #2;
        check("lu_release", 32'(stall), 0);
        check("lu_bubble_sel", sel(0), 0);
        step();
        idle();
        check("lu_sel0_wb", sel(0), 2);
        check("lu_sel1_wb", sel(1), 2);
        step();
        check("lu_stall_cnt", stall_cnt, pc(1));
        check("lu_fwd_cnt", fwd_cnt, pc(2));
        pulse_reset();

        // Writes to $0 everywhere, including a load; consumer reads $0.
        set_id(1, 0, 1, 0, 1, 1, 1, 1);
        step();
        step();
        set_id(1, 0, 1, 1, 1, 0, 1, 0);
        step();
        set_id(1, 9, 1, 0, 0, 0, 1, 1);
        #2;
        check("r0_stall", 32'(stall), 0);
        step();
        check("r0_sel0", sel(0), 0);
        check("r0_sel1", sel(1), 0);
        idle();
        pulse_reset();

        // $7 written in both MEM and WB: youngest (MEM) wins.
        set_id(1, 7, 1, 0, 1, 1, 1, 1);
        step();
        set_id(1, 7, 1, 0, 2, 2, 1, 1);
        step();
        set_id(1, 9, 1, 0, 7, 7, 1, 1);
        step();
        check("young_sel0", sel(0), 1);
        check("young_sel1", sel(1), 1);
        idle();
        pulse_reset();

        // Younger ALU write shadows an older load: no stall.
        set_id(1, 2, 1, 1, 29, 0, 1, 0);
        step();
        idle();
        step();
        set_id(1, 2, 1, 0, 1, 0, 1, 0);
        step();
        set_id(1, 3, 1, 0, 2, 0, 1, 0);
        #2;
        check("shadow_nostall", 32'(stall), 0);
        idle();
        pulse_reset();

        // Load-use with flush: flush wins and a bubble enters EX.
        set_id(1, 2, 1, 1, 29, 0, 1, 0);
        step();
        set_id(1, 10, 1, 0, 2, 2, 1, 1);
        flush = 1'b1;
        #2;
        check("flush_stall", 32'(stall), 0);
        step();
        flush = 1'b0;
        set_id(1, 0, 0, 0, 10, 2, 1, 1);
        step();
        check("flush_bubble_sel0", sel(0), 0);
        check("flush_lw_sel1", sel(1), 2);
        // Freeze for three edges.
        adv = 1'b0;
        set_id(1, 0, 0, 0, 2, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_sel0", sel(0), 0);
            check("hold_sel1", sel(1), 2);
        end
        adv = 1'b1;
        step();
        check("resume_sel1", sel(1), 0);
        check("resume_sel0", sel(0), 0);
        idle();
        pulse_reset();

        // Back-to-back loads to $2, each stalls one cycle.
        set_id(1, 2, 1, 1, 29, 0, 1, 0);
        step();
        set_id(1, 2, 1, 1, 2, 0, 1, 0);
        #2;
        check("ll_stall1", 32'(stall), 1);
        step();
        #2;
        check("ll_release1", 32'(stall), 0);
        step();
        set_id(1, 6, 1, 0, 2, 0, 1, 0);
        #2;
        check("ll_stall2", 32'(stall), 1);
        step();
        #2;
        check("ll_release2", 32'(stall), 0);
        idle();
        pulse_reset();

        // Asynchronous reset while stalling and forwarding.
        set_id(1, 5, 1, 0, 1, 1, 1, 1);
        step();
        set_id(1, 2, 1, 1, 5, 0, 1, 0);
        step();
        check("pre_rst_sel0", sel(0), 1);
        set_id(1, 6, 1, 0, 2, 5, 1, 1);
        #1;
        check("pre_rst_stall", 32'(stall), 1);
        reset = 1'b1;
        #1;
        check("async_rst_stall", 32'(stall), 0);
        check("async_rst_sel", 32'(fwd_sel), 0);
        check("async_rst_stall_cnt", stall_cnt, 0);
        check("async_rst_fwd_cnt", fwd_cnt, 0);
        #1;
        reset = 1'b0;
        #1;
        check("post_rst_stall", 32'(stall), 0);
        step();
        check("post_rst_sel0", sel(0), 0);
        check("post_rst_sel1", sel(1), 0);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
